// File: rtl/ex_div_if.sv
// ex_div_if: EX-stage handshake between the pipeline and the divide sequencer
interface ex_div_if #(parameter int XLEN = 32);
  logic            div_valid;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            flush;
  logic            div_stall;
  logic            div_done;
  logic [XLEN-1:0] div_result;
  modport master (output div_valid, funct3, op1, op2, flush, input div_stall, div_done, div_result);
  modport slave (input div_valid, funct3, op1, op2, flush, output div_stall, div_done, div_result);
endinterface

// File: rtl/ex_div_sequencer.sv
// ex_div_sequencer: iterative restoring RV32M divide/remainder with pipeline stall
module ex_div_sequencer #(
  parameter int XLEN = 32,
  parameter int CNT_WIDTH = 6
) (
  input logic clk,
  input logic rst,
  ex_div_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [CNT_WIDTH-1:0] cnt;
  logic [XLEN-1:0] dvs, quot, rem, result;
  logic is_rem, q_neg, r_neg;
  logic start, sgn, a_neg, b_neg, by_zero, ovf, special, ge, last;
  logic [XLEN-1:0] a_abs, b_abs, quot_n, rem_n, q_fix, r_fix;
  logic [XLEN:0] trial;
  assign start = bus.div_valid & bus.funct3[2] & ~bus.flush;
  assign sgn = ~bus.funct3[0];
  assign a_neg = sgn & bus.op1[XLEN-1];
  assign b_neg = sgn & bus.op2[XLEN-1];
  assign a_abs = a_neg ? -bus.op1 : bus.op1;
  assign b_abs = b_neg ? -bus.op2 : bus.op2;
  assign by_zero = bus.op2 == '0;
  assign ovf = sgn & (bus.op1 == {1'b1, {(XLEN-1){1'b0}}}) & (bus.op2 == '1);
  assign special = by_zero | ovf;
  // Partial remainder can reach 2*divisor after the shift, so the trial needs one extra bit
  assign trial = {rem, quot[XLEN-1]} - {1'b0, dvs};
  assign ge = ~trial[XLEN];
  assign rem_n = ge ? trial[XLEN-1:0] : {rem[XLEN-2:0], quot[XLEN-1]};
  assign quot_n = {quot[XLEN-2:0], ge};
  assign q_fix = q_neg ? -quot_n : quot_n;
  assign r_fix = r_neg ? -rem_n : rem_n;
  assign last = cnt == CNT_WIDTH'(1);
  assign bus.div_result = result;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (start ? (special ? DONE : RUN) : IDLE)
            : state == RUN ? (bus.flush ? IDLE : (last ? DONE : RUN))
            : IDLE;
  end
  always_comb begin
    bus.div_stall = (state == IDLE & start) | (state == RUN & ~bus.flush);
    bus.div_done = state == DONE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      dvs <= '0;
      quot <= '0;
      rem <= '0;
      result <= '0;
      is_rem <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (state == IDLE && start) begin
      is_rem <= bus.funct3[1];
      dvs <= b_abs;
      quot <= a_abs;
      rem <= '0;
      q_neg <= a_neg ^ b_neg;
      r_neg <= a_neg;
      cnt <= CNT_WIDTH'(XLEN);
      if (special)
        result <= bus.funct3[1] ? (by_zero ? bus.op1 : '0)
                                : (by_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}});
    end else if (state == RUN) begin
      quot <= quot_n;
      rem <= rem_n;
      cnt <= cnt - 1'b1;
      if (last && !bus.flush) result <= is_rem ? r_fix : q_fix;
    end
endmodule
